alu_frame_rx: RTL
=================

// Module: alu_frame_rx
// PURPOSE
//  Serial frame receiver at the ALU input. Deserialises the 99-bit sin frame (8 data packets + 1 cmd packet),
//  rebuilds operands B and A, opcode and CRC, checks frame integrity and emits one result per frame.
//  Output feeds the ALU core; its status selects the ERR_DATA / ERR_CRC / ERR_OP response path.
// PARAMETERS
//  N_DATA_PKT   8   data packets per frame (B bytes MSB-first, then A bytes MSB-first)
//  PKT_BITS     11  bits per packet: start(0), type, 8 payload, stop(1)
//  CRC_W        4   CRC width; polynomial x^4+x+1, init 0, over {B,A,1'b1,op} (68 bits, MSB first)
// PORTS
//  clk        in   1   system clock; sin is sampled on posedge
//  rst        in   1   reset, synchronous, active-high
//  sin        in   1   serial input; idles high
//  o_valid    out  1   one-cycle pulse: frame complete, outputs below are valid
//  o_b        out  32  operand B (first four data packets)
//  o_a        out  32  operand A (last four data packets)
//  o_op       out  3   opcode from cmd packet bits [2:4]
//  o_crc      out  4   received CRC from cmd packet bits [5:8]
//  o_status   out  2   frame_status_t: OK / ERR_DATA / ERR_CRC / ERR_OP
// BEHAVIOUR
//  - Reset: o_valid=0, o_b=o_a=0, o_op=0, o_crc=0, o_status=OK. FSM goes to IDLE, all counters and flags clear.
//    Reset mid-frame drops the partial frame and produces no o_valid.
//  - Packet RX (sub-module): in IDLE, sin==0 on posedge is the start bit. It then samples 10 more bits on
//    consecutive posedges (type, d7..d0, stop). pkt_done pulses in the stop-bit cycle and the unit returns to IDLE.
//    A new start bit is accepted in the very next cycle, so back-to-back packets work with no idle gap.
//  - Stop bit == 0: packet is framing-bad; frame bad_data flag set; packet still counted.
//  - Frame FSM states: F_DATA, F_CMD, F_OUT.
//    F_DATA: data packet (type=0) shifts its byte into a 64-bit {B,A} register and increments data_cnt (saturates at 15).
//            Cmd packet (type=1) goes to F_CMD with the payload latched.
//    F_CMD: one cycle to evaluate the checks.
//      ERR_DATA if data_cnt != N_DATA_PKT, bad_data set, or cmd payload bit7 != 0.
//      Otherwise ERR_CRC if crc4({B,A,1'b1,op}) != received CRC.
//      Otherwise ERR_OP if op not in {AND=000, OR=001, ADD=100, SUB=101}.
//      Otherwise OK. Priority is DATA > CRC > OP.
//    F_OUT: registers o_* and pulses o_valid, clears data_cnt and flags, returns to F_DATA.
//  - Latency: o_valid is high exactly 2 cycles after the posedge that samples the cmd stop bit.
//    o_b/o_a/o_op/o_crc/o_status hold until the next o_valid.
//  - If an ERR frame has fewer than 8 data packets, o_b/o_a show the register contents as-is; they are don't-care.
//  - More than 8 data packets: the shift register keeps the last 8 bytes; data_cnt>8 gives ERR_DATA.
//  - A start bit that arrives while in F_CMD/F_OUT is still captured: the packet RX runs independently of the frame FSM.
// STRUCTURE
//  - alu_pkg (shared): operation_t codes, frame_status_t, PKT_BITS/N_DATA_PKT constants,
//    function crc4_68(bit[67:0]) (also used by the bench scoreboard).
//  - Sub-module alu_pkt_rx: start detect, 4-bit bit counter, 10-bit shift register.
//    Outputs pkt_done, pkt_type, pkt_byte, pkt_stop_err.
//  - alu_frame_rx: frame FSM, data_cnt, 64-bit operand shifter, checker, output registers.
// TESTING
//  1 B=32'h0000_0003, A=32'h0000_0005, op=ADD(100), CRC=crc4_68 -> o_valid pulse 2 cycles after stop;
//    o_b=3, o_a=5, o_op=100, o_status=OK.
//  2 Same frame with 7 data packets before cmd -> single o_valid, o_status=ERR_DATA.
//  3 B=32'hFFFF_FFFF, A=32'h1, op=AND, CRC bit0 inverted -> o_status=ERR_CRC, o_crc = sent value.
//  4 op=3'b111 with correct CRC over it -> o_status=ERR_OP.
//  5 rst high for 1 cycle after 40 frame bits, then the full frame of test 1 -> exactly one o_valid
//    (status OK, o_b=3); no pulse for the aborted frame.
//  6 Frames of tests 1 and 3 back-to-back, no idle gap -> two o_valid pulses 99 cycles apart: OK, then ERR_CRC.
//    Stop bit forced 0 in data packet 4 -> ERR_DATA.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU serial frame receiver: frame geometry
// constants, opcode and frame status encodings, and the 4-bit frame CRC.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int N_DATA_PKT = 8;   // data packets per frame
  localparam int PKT_BITS   = 11;  // start, type, 8 payload, stop
  localparam int CRC_W      = 4;

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b100,
    OP_SUB = 3'b101
  } operation_t;

  typedef enum logic [1:0] {
    ST_OK       = 2'd0,
    ST_ERR_DATA = 2'd1,
    ST_ERR_CRC  = 2'd2,
    ST_ERR_OP   = 2'd3
  } frame_status_t;

  // CRC x^4+x+1, init 0, message consumed MSB first.
  function automatic logic [CRC_W-1:0] crc4_68(input logic [67:0] msg);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = '0;
    for (int i = 67; i >= 0; i--) begin
      fb = c[3] ^ msg[i];
      c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
    end
    return c;
  endfunction

endpackage

// File: rtl/alu_pkt_rx.sv
// ---------------------------------------------------------------------------
// alu_pkt_rx
// Receives one 11-bit packet from the serial line: start(0), type, d7..d0,
// stop(1). Runs independently of the frame FSM above it.
// Ports:
//   clk              system clock, i_sin sampled on posedge
//   rst              synchronous active-high reset
//   i_sin            serial input, idles high
//   o_pkt_done       high during the stop-bit cycle of a packet
//   o_pkt_type       packet type bit (0 data, 1 cmd), valid with o_pkt_done
//   o_pkt_byte       payload d7..d0, valid with o_pkt_done
//   o_pkt_stop_err   stop bit sampled as 0, valid with o_pkt_done
// ---------------------------------------------------------------------------
module alu_pkt_rx
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_sin,
  output logic       o_pkt_done,
  output logic       o_pkt_type,
  output logic [7:0] o_pkt_byte,
  output logic       o_pkt_stop_err
);

  // Bits shifted after the start bit before the stop bit arrives (type + 8).
  localparam logic [3:0] LAST_CNT = 4'(PKT_BITS - 2);

  logic       r_busy;
  logic [3:0] r_bit_cnt;
  logic [8:0] r_shift;
  logic       w_at_stop;

  // The stop bit is judged straight off the line so the frame FSM sees the
  // completed packet in the same cycle; the receiver is free again next cycle.
  assign w_at_stop = r_busy && (r_bit_cnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= 1'b0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!r_busy) begin
      if (!i_sin) begin
        r_busy    <= 1'b1;
        r_bit_cnt <= '0;
      end
    end else if (w_at_stop) begin
      r_busy <= 1'b0;
    end else begin
      r_shift   <= {r_shift[7:0], i_sin};
      r_bit_cnt <= r_bit_cnt + 4'd1;
    end
  end

  assign o_pkt_done     = w_at_stop;
  assign o_pkt_type     = r_shift[8];
  assign o_pkt_byte     = r_shift[7:0];
  assign o_pkt_stop_err = w_at_stop && !i_sin;

endmodule

// File: rtl/alu_frame_rx.sv
// ---------------------------------------------------------------------------
// alu_frame_rx
// Assembles 8 data packets and 1 cmd packet into operands B/A, opcode and
// CRC, checks frame integrity and presents one result per frame.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   sin        serial input, idles high
//   o_valid    one-cycle pulse, outputs below updated
//   o_b, o_a   operands (B = first four data bytes, A = last four)
//   o_op       opcode, cmd payload d6..d4
//   o_crc      received CRC, cmd payload d3..d0
//   o_status   OK / ERR_DATA / ERR_CRC / ERR_OP
//
// state  | meaning
// F_DATA | collecting data packets, waiting for the cmd packet
// F_CMD  | cmd latched, evaluating frame checks
// F_OUT  | load outputs, pulse o_valid, clear per-frame counters
// ---------------------------------------------------------------------------
module alu_frame_rx
  import alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sin,
  output logic                 o_valid,
  output logic [31:0]          o_b,
  output logic [31:0]          o_a,
  output logic [2:0]           o_op,
  output logic [CRC_W-1:0]     o_crc,
  output frame_status_t        o_status
);

  typedef enum logic [1:0] {F_DATA, F_CMD, F_OUT} frame_state_t;

  logic             w_pkt_done;
  logic             w_pkt_type;
  logic [7:0]       w_pkt_byte;
  logic             w_pkt_stop_err;

  frame_state_t     r_state;
  logic [3:0]       r_data_cnt;
  logic             r_bad_data;
  logic [63:0]      r_ba;
  logic [7:0]       r_cmd;
  frame_status_t    r_eval;

  logic             r_valid;
  logic [31:0]      r_b;
  logic [31:0]      r_a;
  logic [2:0]       r_op;
  logic [CRC_W-1:0] r_crc;
  frame_status_t    r_status;

  logic [2:0]       w_cmd_op;
  logic [CRC_W-1:0] w_cmd_crc;
  logic [CRC_W-1:0] w_crc_calc;
  frame_status_t    w_status;

  alu_pkt_rx u_pkt_rx (
    .clk            (clk),
    .rst            (rst),
    .i_sin          (sin),
    .o_pkt_done     (w_pkt_done),
    .o_pkt_type     (w_pkt_type),
    .o_pkt_byte     (w_pkt_byte),
    .o_pkt_stop_err (w_pkt_stop_err)
  );

  // Cmd payload: d7 reserved (must be 0), d6..d4 opcode, d3..d0 CRC.
  assign w_cmd_op   = r_cmd[6:4];
  assign w_cmd_crc  = r_cmd[3:0];
  assign w_crc_calc = crc4_68({r_ba, 1'b1, w_cmd_op});

  always_comb begin
    w_status = ST_OK;
    if ((r_data_cnt != 4'(N_DATA_PKT)) || r_bad_data || r_cmd[7])
      w_status = ST_ERR_DATA;
    else if (w_crc_calc != w_cmd_crc)
      w_status = ST_ERR_CRC;
    else if (!(w_cmd_op inside {OP_AND, OP_OR, OP_ADD, OP_SUB}))
      w_status = ST_ERR_OP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= F_DATA;
      r_data_cnt <= '0;
      r_bad_data <= 1'b0;
      r_ba       <= '0;
      r_cmd      <= '0;
      r_eval     <= ST_OK;
      r_valid    <= 1'b0;
      r_b        <= '0;
      r_a        <= '0;
      r_op       <= '0;
      r_crc      <= '0;
      r_status   <= ST_OK;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        F_DATA: begin
          if (w_pkt_done) begin
            if (w_pkt_stop_err)
              r_bad_data <= 1'b1;
            if (!w_pkt_type) begin
              // Oldest byte falls off the top, so excess packets keep the last 8.
              r_ba <= {r_ba[55:0], w_pkt_byte};
              if (r_data_cnt != 4'hF)
                r_data_cnt <= r_data_cnt + 4'd1;
            end else begin
              r_cmd   <= w_pkt_byte;
              r_state <= F_CMD;
            end
          end
        end
        F_CMD: begin
          r_eval  <= w_status;
          r_state <= F_OUT;
        end
        F_OUT: begin
          r_b        <= r_ba[63:32];
          r_a        <= r_ba[31:0];
          r_op       <= w_cmd_op;
          r_crc      <= w_cmd_crc;
          r_status   <= r_eval;
          r_valid    <= 1'b1;
          r_data_cnt <= '0;
          r_bad_data <= 1'b0;
          r_state    <= F_DATA;
        end
        default: r_state <= F_DATA;
      endcase
    end
  end

  assign o_valid  = r_valid;
  assign o_b      = r_b;
  assign o_a      = r_a;
  assign o_op     = r_op;
  assign o_crc    = r_crc;
  assign o_status = r_status;

endmodule
